codificador_escalonador: RTL and testbench

- Round-robin scheduler that shares one Codificador (4-bit encoder: inputs A,B,C,D, ready, reset; outputs S0..S3) among NREQ requesters.
- Per job: grants a requester, clears the encoder with a reset pulse, presents the 4-bit word with ready high, waits the encoder latency, captures S3..S0 and returns the result with an ack.
- Sits between the requester logic and the single Codificador instance.

---
 rtl/codificador_pkg.sv | 21 ++
 rtl/codificador_escalonador_if.sv | 24 ++
 rtl/codificador_escalonador_rr_arbiter.sv | 28 ++
 rtl/codificador_escalonador.sv | 141 ++++++++++++++
 tb/tb_codificador_escalonador.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/codificador_pkg.sv
// rtl/codificador_pkg.sv - shared types, widths and round-robin helper for the encoder scheduler
package codificador_pkg;

    localparam int W_DADO = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        WAIT,
        DONE
    } estado_t;

    function automatic logic [2:0] next_rr(input logic [2:0] ptr, input int nreq);
        if (int'(ptr) >= nreq - 1) begin
            return 3'd0;
        end
        return ptr + 3'd1;
    endfunction

endpackage

// File: rtl/codificador_escalonador_if.sv
// rtl/codificador_escalonador_if.sv - link between the scheduler and the shared Codificador
interface codificador_escalonador_if;
    import codificador_pkg::*;

    logic [W_DADO-1:0] enc_dado;
    logic              enc_ready;
    logic              enc_reset;
    logic [W_DADO-1:0] enc_s;

    modport master (
        output enc_dado,
        output enc_ready,
        output enc_reset,
        input  enc_s
    );

    modport slave (
        input  enc_dado,
        input  enc_ready,
        input  enc_reset,
        output enc_s
    );

endinterface

// File: rtl/codificador_escalonador_rr_arbiter.sv
// rtl/codificador_escalonador_rr_arbiter.sv - combinational round-robin arbiter, priority rotated from ptr
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            grant_valid,
    output logic [2:0]      grant_id
);

    always_comb begin
        int              idx;
        logic [NREQ-1:0] shifted;
        grant_valid = 1'b0;
        grant_id    = 3'd0;
        idx         = 0;
        shifted     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx     = (int'(ptr) + k) % NREQ;
            shifted = req >> idx;
            if (!grant_valid && shifted[0]) begin
                grant_valid = 1'b1;
                grant_id    = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/codificador_escalonador.sv
// rtl/codificador_escalonador.sv - round-robin scheduler sharing one Codificador among NREQ requesters
module codificador_escalonador
    import codificador_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ENC_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [W_DADO*NREQ-1:0]   req_dado,
    output logic [NREQ-1:0]          ack,
    output logic                     res_valid,
    output logic [2:0]               res_id,
    output logic [W_DADO-1:0]        res_dado,
    output logic                     busy,
    codificador_escalonador_if.master enc
);

    estado_t           state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        id_q, id_d;
    logic [W_DADO-1:0] dado_q, dado_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              res_valid_q, res_valid_d;
    logic [2:0]        res_id_q, res_id_d;
    logic [W_DADO-1:0] res_dado_q, res_dado_d;
    logic              busy_q, busy_d;
    logic [W_DADO-1:0] enc_dado_q, enc_dado_d;
    logic              enc_ready_q, enc_ready_d;
    logic              enc_reset_q, enc_reset_d;

    logic              grant_valid;
    logic [2:0]        grant_id;
    logic [W_DADO-1:0] dado_sel;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req         (req),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign dado_sel = W_DADO'(req_dado >> (int'(grant_id) * W_DADO));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        dado_d      = dado_q;
        res_dado_d  = res_dado_q;
        res_id_d    = res_id_q;
        enc_dado_d  = enc_dado_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    id_d    = grant_id;
                    dado_d  = dado_sel;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                cnt_d   = 4'(ENC_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    res_dado_d = enc.enc_s;
                    cnt_d      = 4'd0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ptr_d   = next_rr(id_q, NREQ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        busy_d      = (state_d != IDLE);
        enc_reset_d = (state_d == CLEAR);
        enc_ready_d = (state_d == LOAD) || (state_d == WAIT);
        if (state_d == LOAD) begin
            enc_dado_d = dado_q;
        end
        res_valid_d = (state_d == DONE);
        ack_d       = res_valid_d ? (NREQ'(1) << id_q) : '0;
        if (res_valid_d) begin
            res_id_d = id_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            cnt_q       <= 4'd0;
            id_q        <= 3'd0;
            dado_q      <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 3'd0;
            res_dado_q  <= '0;
            busy_q      <= 1'b0;
            enc_dado_q  <= '0;
            enc_ready_q <= 1'b0;
            enc_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            dado_q      <= dado_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_dado_q  <= res_dado_d;
            busy_q      <= busy_d;
            enc_dado_q  <= enc_dado_d;
            enc_ready_q <= enc_ready_d;
            enc_reset_q <= enc_reset_d;
        end
    end

    assign ack           = ack_q;
    assign res_valid     = res_valid_q;
    assign res_id        = res_id_q;
    assign res_dado      = res_dado_q;
    assign busy          = busy_q;
    assign enc.enc_dado  = enc_dado_q;
    assign enc.enc_ready = enc_ready_q;
    assign enc.enc_reset = enc_reset_q;

endmodule

// File: tb/tb_codificador_escalonador.sv
// tb/tb_codificador_escalonador.sv - directed bench for the encoder scheduler
module tb_codificador_escalonador;

    logic        clk;
    logic        reset;

    logic [3:0]  req;
    logic [15:0] req_dado;
    logic [3:0]  ack;
    logic        res_valid;
    logic [2:0]  res_id;
    logic [3:0]  res_dado;
    logic        busy;

    logic [3:0]  req3;
    logic [15:0] req_dado3;
    logic [3:0]  ack3;
    logic        res_valid3;
    logic [2:0]  res_id3;
    logic [3:0]  res_dado3;
    logic        busy3;
    logic [3:0]  s3_drv;

    int total;
    int bad;

    codificador_escalonador_if e1 ();
    codificador_escalonador_if e3 ();

    assign e1.enc_s = e1.enc_dado ^ 4'b0101;
    assign e3.enc_s = s3_drv;

    codificador_escalonador #(.NREQ(4), .ENC_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_dado  (req_dado),
        .ack       (ack),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_dado  (res_dado),
        .busy      (busy),
        .enc       (e1)
    );

    codificador_escalonador #(.NREQ(4), .ENC_LAT(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .req       (req3),
        .req_dado  (req_dado3),
        .ack       (ack3),
        .res_valid (res_valid3),
        .res_id    (res_id3),
        .res_dado  (res_dado3),
        .busy      (busy3),
        .enc       (e3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until ack is seen; also tallies encoder strobes seen on the way.
    task automatic wait_ack(output int n, output int n_ready, output int n_reset);
        n = 0;
        n_ready = 0;
        n_reset = 0;
        do begin
            @(negedge clk);
            n++;
            if (e1.enc_ready) n_ready++;
            if (e1.enc_reset) n_reset++;
        end while (ack == 4'b0 && n < 40);
    endtask

    initial begin
        int n, nr, nz;
        int bad_hold;
        logic [3:0] exp_res [5];
        int         exp_id  [5];
        total = 0;
        bad   = 0;
        reset = 1'b0;
        req = '0;
        req_dado = '0;
        req3 = '0;
        req_dado3 = '0;
        s3_drv = 4'h3;

        repeat (2) @(negedge clk);
        check("rst_ack", ack, 4'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_id", res_id, 3'd0);
        check("rst_res_dado", res_dado, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_enc_dado", e1.enc_dado, 4'h0);
        check("rst_enc_ready", e1.enc_ready, 1'b0);
        check("rst_enc_reset", e1.enc_reset, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Single request from requester 2.
        req_dado[11:8] = 4'b1001;
        req[2] = 1'b1;
        @(negedge clk);
        check("single_clear_reset", e1.enc_reset, 1'b1);
        check("single_clear_ready", e1.enc_ready, 1'b0);
        check("single_clear_busy", busy, 1'b1);
        @(negedge clk);
        check("single_load_dado", e1.enc_dado, 4'b1001);
        check("single_load_ready", e1.enc_ready, 1'b1);
        check("single_load_reset", e1.enc_reset, 1'b0);
        wait_ack(n, nr, nz);
        check("single_latency", n + 2, 5);
        check("single_ready_cycles", nr + 1, 3);
        check("single_ack", ack, 4'b0100);
        check("single_valid", res_valid, 1'b1);
        check("single_id", res_id, 3'd2);
        check("single_res", res_dado, 4'b1100);
        check("single_done_ready", e1.enc_ready, 1'b0);
        req[2] = 1'b0;
        @(negedge clk);
        check("single_after_ack", ack, 4'b0);
        check("single_after_valid", res_valid, 1'b0);
        check("single_after_busy", busy, 1'b0);
        check("single_res_hold", res_dado, 4'b1100);
        check("single_enc_dado_hold", e1.enc_dado, 4'b1001);

        // Wrap-around: pointer is 3, so 3 goes before 0.
        req_dado[3:0]   = 4'b0000;
        req_dado[15:12] = 4'b1010;
        req[0] = 1'b1;
        req[3] = 1'b1;
        wait_ack(n, nr, nz);
        check("wrap_first_latency", n, 5);
        check("wrap_first_ack", ack, 4'b1000);
        check("wrap_first_id", res_id, 3'd3);
        check("wrap_first_res", res_dado, 4'b1111);
        req[3] = 1'b0;
        @(negedge clk);
        check("wrap_gap_idle", busy, 1'b0);
        wait_ack(n, nr, nz);
        check("wrap_second_latency", n, 5);
        check("wrap_second_ack", ack, 4'b0001);
        check("wrap_second_id", res_id, 3'd0);
        check("wrap_second_res", res_dado, 4'b0101);
        req[0] = 1'b0;
        @(negedge clk);

        // Data change after grant: latched word wins.
        req_dado[3:0] = 4'b0011;
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("chg_load_dado", e1.enc_dado, 4'b0011);
        req_dado[3:0] = 4'b1111;
        bad_hold = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (e1.enc_ready && e1.enc_dado !== 4'b0011) bad_hold++;
        end while (ack == 4'b0 && n < 40);
        check("chg_latency", n, 3);
        check("chg_dado_held", bad_hold, 0);
        check("chg_ack", ack, 4'b0001);
        check("chg_res", res_dado, 4'b0110);
        req[0] = 1'b0;
        @(negedge clk);

        // Reset mid-WAIT drops the job, then requester 1 is served fresh.
        req_dado[7:4] = 4'b0110;
        req[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("rstw_in_wait", e1.enc_ready, 1'b1);
        reset = 1'b0;
        #1;
        check("rstw_busy", busy, 1'b0);
        check("rstw_enc_ready", e1.enc_ready, 1'b0);
        check("rstw_enc_dado", e1.enc_dado, 4'h0);
        check("rstw_res_dado", res_dado, 4'h0);
        check("rstw_ack", ack, 4'b0);
        @(negedge clk);
        reset = 1'b1;
        wait_ack(n, nr, nz);
        check("rstw_latency", n, 5);
        check("rstw_ack_after", ack, 4'b0010);
        check("rstw_id", res_id, 3'd1);
        check("rstw_res", res_dado, 4'b0011);
        req[1] = 1'b0;
        @(negedge clk);

        // Fairness from pointer 0 with all requests held.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_dado = {4'd4, 4'd3, 4'd2, 4'd1};
        exp_id  = '{0, 1, 2, 3, 0};
        exp_res = '{4'b0100, 4'b0111, 4'b0110, 4'b0001, 4'b0100};
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack(n, nr, nz);
            check($sformatf("fair%0d_latency", j), n, (j == 0) ? 5 : 6);
            check($sformatf("fair%0d_ack", j), ack, 32'(1) << exp_id[j]);
            check($sformatf("fair%0d_onehot", j), $countones(ack), 1);
            check($sformatf("fair%0d_id", j), res_id, exp_id[j]);
            check($sformatf("fair%0d_res", j), res_dado, exp_res[j]);
        end
        req = '0;
        @(negedge clk);

        // ENC_LAT=3: enc_s changes in the last WAIT cycle and is still captured.
        req_dado3[3:0] = 4'b0101;
        req3[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 5) s3_drv = 4'hA;
        end while (ack3 == 4'b0 && n < 40);
        check("lat3_latency", n, 6);
        check("lat3_ack", ack3, 4'b0001);
        check("lat3_id", res_id3, 3'd0);
        check("lat3_res", res_dado3, 4'hA);
        req3[0] = 1'b0;
        @(negedge clk);
        check("lat3_after_ack", ack3, 4'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
